// File: rtl/avalon_mm_burst_master.sv
// avalon_mm_burst_master
//   Issues one Avalon-MM burst per command: a read burst whose returned beats
//   are forwarded on rd_data/rd_valid, or a write burst whose beats are pulled
//   from the wr_data/wr_valid/wr_ready stream.
//
// Ports
//   CLK, RESET                  clock, synchronous active-high reset
//   ADDRESS, BURSTCOUNT,
//   BYTE_ENABLE                 burst command, held for the whole burst
//   READ, WRITE, WRITEDATA      Avalon request strobes and write data (registered)
//   READDATA, READDATAVALID,
//   WAITREQUEST                 Avalon slave responses
//   start, rnw,
//   address_to_access, length,
//   bytes                       command interface, sampled in IDLE only
//   wr_data, wr_valid, wr_ready write-data stream (valid/ready handshake)
//   rd_data, rd_valid           read-data stream, no backpressure
//   done, error                 one-cycle completion / rejection pulses
module avalon_mm_burst_master #(
   parameter  int DATA_W    = 32,
   parameter  int ADDR_W    = 32,
   parameter  int MAX_BURST = 8,
   localparam int BC_W      = $clog2(MAX_BURST) + 1,
   localparam int BE_W      = DATA_W / 8
) (
   input  logic              CLK,
   input  logic              RESET,
   // Avalon-MM master
   output logic [ADDR_W-1:0] ADDRESS,
   output logic [BC_W-1:0]   BURSTCOUNT,
   output logic [BE_W-1:0]   BYTE_ENABLE,
   output logic              READ,
   output logic              WRITE,
   output logic [DATA_W-1:0] WRITEDATA,
   input  logic [DATA_W-1:0] READDATA,
   input  logic              WAITREQUEST,
   input  logic              READDATAVALID,
   // command
   input  logic              start,
   input  logic              rnw,
   input  logic [ADDR_W-1:0] address_to_access,
   input  logic [BC_W-1:0]   length,
   input  logic [BE_W-1:0]   bytes,
   // write stream
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   // read stream
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   // status
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_REQ   = 3'd1,
      RD_DATA  = 3'd2,
      WR_BURST = 3'd3,
      DONE     = 3'd4
   } state_t;

   localparam logic [BC_W-1:0] MAX_BC = BC_W'(MAX_BURST);
   localparam logic [BC_W-1:0] ONE    = BC_W'(1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [BC_W-1:0]     bc_q, bc_d;
   logic [BE_W-1:0]     be_q, be_d;
   logic                read_q, read_d;
   logic                write_q, write_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                rvalid_q, rvalid_d;
   logic                err_q, err_d;
   // cnt: beats finished on the bus (read: received, write: completed)
   // acc: write beats already taken from the stream
   logic [BC_W-1:0]     cnt_q, cnt_d;
   logic [BC_W-1:0]     acc_q, acc_d;

   logic                len_ok;
   logic                rdv_ok;
   logic [BC_W-1:0]     cnt_inc;
   logic                wr_accept;
   logic                wr_beat_done;

   assign len_ok  = (length != '0) && (length <= MAX_BC);

   // Read data is only meaningful while a read burst is outstanding; the
   // acceptance cycle of RD_REQ already counts.
   assign rdv_ok  = READDATAVALID && ((state_q == RD_REQ) || (state_q == RD_DATA));
   assign cnt_inc = rdv_ok ? (cnt_q + ONE) : cnt_q;

   // A new beat may be taken when the WRITE register is free or is being
   // consumed by the slave this cycle, and only while beats remain.
   assign wr_ready     = (state_q == WR_BURST) && (acc_q < bc_q) &&
                         (!write_q || !WAITREQUEST);
   assign wr_accept    = wr_ready && wr_valid;
   assign wr_beat_done = (state_q == WR_BURST) && write_q && !WAITREQUEST;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      bc_d     = bc_q;
      be_d     = be_q;
      read_d   = read_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      err_d    = 1'b0;
      cnt_d    = cnt_q;
      acc_d    = acc_q;

      if (rdv_ok) begin
         rvalid_d = 1'b1;
         rdata_d  = READDATA;
         cnt_d    = cnt_inc;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               if (len_ok) begin
                  addr_d = address_to_access;
                  bc_d   = length;
                  be_d   = bytes;
                  cnt_d  = '0;
                  acc_d  = '0;
                  if (rnw) begin
                     read_d  = 1'b1;
                     state_d = RD_REQ;
                  end else begin
                     state_d = WR_BURST;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         RD_REQ: begin
            if (!WAITREQUEST) begin
               read_d  = 1'b0;
               // a length-1 burst can complete in its own acceptance cycle
               state_d = (cnt_inc == bc_q) ? DONE : RD_DATA;
            end
         end

         RD_DATA: begin
            if (cnt_inc == bc_q) state_d = DONE;
         end

         WR_BURST: begin
            if (wr_beat_done) cnt_d = cnt_q + ONE;
            if (wr_accept) begin
               write_d = 1'b1;
               wdata_d = wr_data;
               acc_d   = acc_q + ONE;
            end else if (wr_beat_done) begin
               write_d = 1'b0;   // stream bubble: drop WRITE, keep the command
            end
            if (wr_beat_done && ((cnt_q + ONE) == bc_q)) begin
               write_d = 1'b0;
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
            addr_d  = '0;
            bc_d    = '0;
            be_d    = '0;
            wdata_d = '0;
            cnt_d   = '0;
            acc_d   = '0;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         bc_q     <= '0;
         be_q     <= '0;
         read_q   <= 1'b0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         bc_q     <= bc_d;
         be_q     <= be_d;
         read_q   <= read_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
      end
   end

   assign ADDRESS     = addr_q;
   assign BURSTCOUNT  = bc_q;
   assign BYTE_ENABLE = be_q;
   assign READ        = read_q;
   assign WRITE       = write_q;
   assign WRITEDATA   = wdata_q;
   assign rd_data     = rdata_q;
   assign rd_valid    = rvalid_q;
   assign error       = err_q;
   assign done        = (state_q == DONE);

endmodule

// File: tb/tb_avalon_mm_burst_master.sv
// Directed bench for avalon_mm_burst_master (DATA_W=32, ADDR_W=32, MAX_BURST=8).
module tb_avalon_mm_burst_master;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int BCW = 4;
   localparam int BEW = 4;

   logic           CLK = 1'b0;
   logic           RESET = 1'b1;
   logic [AW-1:0]  ADDRESS;
   logic [BCW-1:0] BURSTCOUNT;
   logic [BEW-1:0] BYTE_ENABLE;
   logic           READ, WRITE;
   logic [DW-1:0]  WRITEDATA;
   logic [DW-1:0]  READDATA = '0;
   logic           WAITREQUEST = 1'b0;
   logic           READDATAVALID = 1'b0;
   logic           start = 1'b0;
   logic           rnw = 1'b0;
   logic [AW-1:0]  address_to_access = '0;
   logic [BCW-1:0] length = '0;
   logic [BEW-1:0] bytes = '0;
   logic [DW-1:0]  wr_data = '0;
   logic           wr_valid = 1'b0;
   logic           wr_ready;
   logic [DW-1:0]  rd_data;
   logic           rd_valid;
   logic           done, error;

   always #5 CLK = ~CLK;

   avalon_mm_burst_master #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(8)) dut (
      .CLK(CLK), .RESET(RESET),
      .ADDRESS(ADDRESS), .BURSTCOUNT(BURSTCOUNT), .BYTE_ENABLE(BYTE_ENABLE),
      .READ(READ), .WRITE(WRITE), .WRITEDATA(WRITEDATA),
      .READDATA(READDATA), .WAITREQUEST(WAITREQUEST), .READDATAVALID(READDATAVALID),
      .start(start), .rnw(rnw), .address_to_access(address_to_access),
      .length(length), .bytes(bytes),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .done(done), .error(error)
   );

   logic [127:0] all_out;
   assign all_out = {18'd0, ADDRESS, BURSTCOUNT, BYTE_ENABLE, READ, WRITE, WRITEDATA,
                     rd_data, rd_valid, wr_ready, done, error};

   int n_chk = 0;
   int n_err = 0;

   // bus monitor
   int          wcnt = 0, rcnt = 0, dcnt = 0, ecnt = 0, rdhi = 0;
   logic [31:0] wlog [64];
   logic [31:0] rlog [64];

   always @(negedge CLK) begin
      if (WRITE && !WAITREQUEST) begin
         if (wcnt < 64) wlog[wcnt] <= WRITEDATA;
         wcnt <= wcnt + 1;
      end
      if (rd_valid) begin
         if (rcnt < 64) rlog[rcnt] <= rd_data;
         rcnt <= rcnt + 1;
      end
      if (done)  dcnt <= dcnt + 1;
      if (error) ecnt <= ecnt + 1;
      if (READ)  rdhi <= rdhi + 1;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK); #1;
   endtask

   // presents a command for one cycle; returns in the first cycle of the burst
   task automatic cmd(input logic r, input logic [31:0] a, input logic [3:0] l,
                      input logic [3:0] be);
      start = 1'b1; rnw = r; address_to_access = a; length = l; bytes = be;
      tick;
      start = 1'b0;
   endtask

   task automatic run_read(input logic [31:0] a, input logic [3:0] l,
                           input logic [31:0] wr_pat, input logic [31:0] rdv_pat,
                           input int ncyc);
      int   sent = 0;
      int   bad  = 0;
      logic prev = 1'b0;
      cmd(1'b1, a, l, 4'hF);
      for (int i = 0; i < ncyc; i++) begin
         WAITREQUEST   = wr_pat[i];
         READDATAVALID = rdv_pat[i];
         READDATA      = rdv_pat[i] ? (32'hA0 + sent) : 32'hDEADBEEF;
         if (rdv_pat[i]) sent++;
         @(negedge CLK);
         if (i == 0) chk("rd_burstcount", BURSTCOUNT, l);
         if (READ && (ADDRESS != a || BURSTCOUNT != l)) bad++;
         if (rd_valid !== prev) bad++;
         prev = rdv_pat[i];
         tick;
      end
      WAITREQUEST = 1'b0; READDATAVALID = 1'b0;
      chk("rd_cmd_and_latency", bad, 0);
   endtask

   task automatic run_write(input logic [31:0] a, input logic [3:0] l,
                            input logic [31:0] wr_pat, input int ncyc);
      int   k   = 0;
      int   bad = 0;
      logic gap = 1'b0;
      cmd(1'b0, a, l, 4'hC);
      for (int i = 0; i < ncyc; i++) begin
         WAITREQUEST = wr_pat[i % 32];
         wr_valid    = (k < int'(l)) && !gap;
         wr_data     = 32'hD000_0000 + k;
         @(negedge CLK);
         if (wr_valid && wr_ready) begin k++; gap = 1'b1; end
         else gap = 1'b0;
         if (WRITE && (ADDRESS != a || BURSTCOUNT != l || BYTE_ENABLE != 4'hC)) bad++;
         tick;
      end
      wr_valid = 1'b0; WAITREQUEST = 1'b0;
      chk("wr_cmd_stable", bad, 0);
   endtask

   initial begin
      int wb, rb, db, eb, hb;

      // reset
      tick; tick;
      @(negedge CLK);
      chk("reset_outputs", all_out, 128'd0);
      tick;
      RESET = 1'b0;
      tick;

      // read len 4, two wait cycles, gapped READDATAVALID
      rb = rcnt; db = dcnt; hb = rdhi;
      run_read(32'h0000_1000, 4'd4, 32'h3, 32'h2A8, 14);
      chk("rd4_read_cycles", rdhi - hb, 3);
      chk("rd4_beats", rcnt - rb, 4);
      for (int j = 0; j < 4; j++) chk("rd4_data", rlog[rb + j], 32'hA0 + j);
      chk("rd4_done", dcnt - db, 1);

      // write len 8 (=MAX_BURST), gapped stream, pseudo-random waitrequest
      wb = wcnt; db = dcnt;
      run_write(32'h0000_2000, 4'd8, 32'h6A5C_93B4, 64);
      chk("wr8_beats", wcnt - wb, 8);
      for (int j = 0; j < 8; j++) chk("wr8_data", wlog[wb + j], 32'hD000_0000 + j);
      chk("wr8_done", dcnt - db, 1);
      chk("wr8_idle_addr", ADDRESS, 0);

      // illegal lengths
      db = dcnt; eb = ecnt;
      cmd(1'b1, 32'h5000, 4'd0, 4'hF);
      @(negedge CLK);
      chk("len0_error", error, 1);
      chk("len0_no_bus", {READ, WRITE}, 2'b00);
      tick;
      @(negedge CLK);
      chk("len0_error_pulse", error, 0);
      tick;
      cmd(1'b0, 32'h5000, 4'd9, 4'hF);
      @(negedge CLK);
      chk("len9_error", error, 1);
      chk("len9_no_bus", {READ, WRITE, wr_ready}, 3'b000);
      tick; tick; tick;
      chk("bad_len_no_done", dcnt - db, 0);
      chk("bad_len_errors", ecnt - eb, 2);

      // READDATAVALID while idle is ignored
      rb = rcnt;
      READDATAVALID = 1'b1; READDATA = 32'h55;
      tick; tick; tick;
      READDATAVALID = 1'b0;
      tick;
      chk("idle_rdv_ignored", rcnt - rb, 0);

      // read len 1, data in the acceptance cycle
      rb = rcnt; db = dcnt; hb = rdhi;
      run_read(32'h0000_4000, 4'd1, 32'h1, 32'h2, 6);
      chk("rd1_read_cycles", rdhi - hb, 2);
      chk("rd1_beats", rcnt - rb, 1);
      chk("rd1_data", rlog[rb], 32'hA0);
      chk("rd1_done", dcnt - db, 1);

      // reset in the middle of a 6-beat write, after the 3rd beat
      wb = wcnt; db = dcnt;
      run_write(32'h0000_6000, 4'd6, 32'h0, 6);
      chk("wr6_beats_before_reset", wcnt - wb, 3);
      RESET = 1'b1;
      tick;
      @(negedge CLK);
      chk("midburst_reset_outputs", all_out, 128'd0);
      tick;
      RESET = 1'b0;
      tick;
      chk("wr6_no_done", dcnt - db, 0);
      rb = rcnt; db = dcnt;
      run_read(32'h0000_3000, 4'd2, 32'h0, 32'h6, 6);
      chk("post_reset_rd_beats", rcnt - rb, 2);
      chk("post_reset_rd_data", {rlog[rb], rlog[rb + 1]}, {32'hA0, 32'hA1});
      chk("post_reset_rd_done", dcnt - db, 1);

      // start held across done; start during a burst is ignored
      wb = wcnt; db = dcnt;
      start = 1'b1; rnw = 1'b0; address_to_access = 32'h7000; length = 4'd1; bytes = 4'h3;
      wr_valid = 1'b1; wr_data = 32'h11;
      tick;                                  // burst 1 entered
      address_to_access = 32'h8000;
      @(negedge CLK);
      chk("b2b_addr_a", ADDRESS, 32'h7000);
      chk("b2b_ready", wr_ready, 1);
      tick;                                  // WRITE with 0x11
      wr_data = 32'h22;
      @(negedge CLK);
      chk("b2b_write_a", {WRITE, ADDRESS}, {1'b1, 32'h7000});
      tick;
      @(negedge CLK);
      chk("b2b_done1", {done, ADDRESS}, {1'b1, 32'h7000});
      tick;                                  // IDLE, start still high
      @(negedge CLK);
      chk("b2b_idle_gap", {done, ADDRESS}, {1'b0, 32'h0});
      tick;
      start = 1'b0;
      @(negedge CLK);
      chk("b2b_addr_b", ADDRESS, 32'h8000);
      for (int i = 0; i < 6; i++) tick;
      wr_valid = 1'b0;
      tick;
      chk("b2b_beats", wcnt - wb, 2);
      chk("b2b_data", {wlog[wb], wlog[wb + 1]}, {32'h11, 32'h22});
      chk("b2b_done_count", dcnt - db, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
